// File: rtl/fwd_hazard_ctrl_if.sv
// Bundle between the ID/EX pipeline and the forwarding/hazard controller.
// The pipeline side (master) presents the decoded ID instruction and the
// data-memory ready flag; the controller side (slave) returns stall, bubble,
// the EX operand mux selects and the sticky memory-wait error.
interface fwd_hazard_ctrl_if #(
    parameter int REG_AW = 5
);
    logic              id_valid;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic [REG_AW-1:0] id_rd;
    logic              id_regwrite;
    logic              id_memread;
    logic              mem_ready;
    logic              stall;
    logic              ex_bubble;
    logic [1:0]        fwd_a_sel;
    logic [1:0]        fwd_b_sel;
    logic              mem_timeout;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rd, id_regwrite, id_memread, mem_ready,
        input  stall, ex_bubble, fwd_a_sel, fwd_b_sel, mem_timeout
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rd, id_regwrite, id_memread, mem_ready,
        output stall, ex_bubble, fwd_a_sel, fwd_b_sel, mem_timeout
    );
endinterface

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and hazard controller for the EX-stage three-input operand muxes.
// Shadows the destination of each in-flight instruction in EX/MEM/WB slots,
// registers the operand selects (00 regfile, 01 WB result, 10 MEM result),
// inserts one bubble on a load-use hazard, freezes while data memory waits,
// and raises a sticky error when a wait runs WAIT_LIMIT cycles.
module fwd_hazard_ctrl #(
    parameter int REG_AW     = 5,
    parameter int WAIT_LIMIT = 16
) (
    input  logic             clk,
    input  logic             rst,
    fwd_hazard_ctrl_if.slave bus
);
    localparam int CNT_W    = $clog2(WAIT_LIMIT + 1);
    localparam int SLOT_EX  = 0;
    localparam int SLOT_MEM = 1;
    localparam int SLOT_WB  = 2;

    typedef struct packed {
        logic              v;
        logic [REG_AW-1:0] rd;
        logic              rw;
        logic              ld;
    } slot_t;

    typedef enum logic [1:0] {
        RUN,
        LOAD_STALL,
        MEM_WAIT
    } state_t;

    state_t           state;
    slot_t            slots [3];
    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] wait_cnt_next;
    logic [1:0]       sel_a_q;
    logic [1:0]       sel_b_q;
    logic             timeout_q;

    logic             load_use;
    logic             bubble;
    logic             stall;
    logic [1:0]       sel_a_d;
    logic [1:0]       sel_b_d;

    // Newest producer wins: the instruction now in EX will sit in MEM when the
    // consumer reaches EX (select 10); the one now in MEM will be in WB (01).
    function automatic logic [1:0] pick_sel(input logic [REG_AW-1:0] rs,
                                            input slot_t ex, input slot_t mem);
        if (rs == '0)                          return 2'b00;
        if (ex.v && ex.rw && ex.rd == rs)      return 2'b10;
        if (mem.v && mem.rw && mem.rd == rs)   return 2'b01;
        return 2'b00;
    endfunction

    // Hazard detection, next wait count and candidate selects for the ID instruction.
    always_comb begin
        // NOTE: every output of this block gets a value on every path, otherwise
        // synthesis would infer a latch to remember the old one.
        load_use = bus.id_valid & slots[SLOT_EX].v & slots[SLOT_EX].ld
                 & (slots[SLOT_EX].rd != '0)
                 & ((slots[SLOT_EX].rd == bus.id_rs1) | (slots[SLOT_EX].rd == bus.id_rs2));
        // The bubble cycle leaves EX empty, so LOAD_STALL can never re-stall;
        // the state check just makes the single-cycle rule explicit.
        bubble   = ~rst & bus.mem_ready & load_use & (state != LOAD_STALL);
        stall    = ~rst & (~bus.mem_ready | bubble);

        wait_cnt_next = wait_cnt;
        if (!bus.mem_ready && wait_cnt != CNT_W'(WAIT_LIMIT))
            wait_cnt_next = wait_cnt + 1'b1;

        sel_a_d = pick_sel(bus.id_rs1, slots[SLOT_EX], slots[SLOT_MEM]);
        sel_b_d = pick_sel(bus.id_rs2, slots[SLOT_EX], slots[SLOT_MEM]);
    end

    // Control FSM: advances slots and selects whenever memory is ready,
    // holds everything but the wait counter while it is not.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            // NOTE: the slot array is reset explicitly because stale valid bits
            // would forward or stall on instructions that no longer exist.
            for (int i = 0; i < 3; i++) slots[i] <= '0;
            wait_cnt  <= '0;
            sel_a_q   <= 2'b00;
            sel_b_q   <= 2'b00;
            timeout_q <= 1'b0;
        end else if (!bus.mem_ready) begin
            // NOTE: non-blocking assignments here so every register samples the
            // pre-edge values, exactly like the flops they describe.
            state     <= MEM_WAIT;
            wait_cnt  <= wait_cnt_next;
            timeout_q <= timeout_q | (wait_cnt_next == CNT_W'(WAIT_LIMIT));
        end else begin
            state           <= bubble ? LOAD_STALL : RUN;
            wait_cnt        <= '0;
            slots[SLOT_WB]  <= slots[SLOT_MEM];
            slots[SLOT_MEM] <= slots[SLOT_EX];
            slots[SLOT_EX]  <= '{v:  bus.id_valid & ~stall,
                                 rd: bus.id_rd,
                                 rw: bus.id_regwrite & (bus.id_rd != '0),
                                 ld: bus.id_memread};
            sel_a_q         <= bubble ? 2'b00 : sel_a_d;
            sel_b_q         <= bubble ? 2'b00 : sel_b_d;
        end
    end

    assign bus.stall       = stall;
    assign bus.ex_bubble   = bubble;
    assign bus.fwd_a_sel   = sel_a_q;
    assign bus.fwd_b_sel   = sel_b_q;
    assign bus.mem_timeout = timeout_q;
endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed bench for fwd_hazard_ctrl: reset, EX/WB forwarding and priority,
// load-use bubble, memory-wait freeze, sticky timeout and async reset mid-wait.
module tb_fwd_hazard_ctrl;
    localparam int REG_AW     = 5;
    localparam int WAIT_LIMIT = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    fwd_hazard_ctrl_if #(.REG_AW(REG_AW)) bus ();

    fwd_hazard_ctrl #(.REG_AW(REG_AW), .WAIT_LIMIT(WAIT_LIMIT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present one ID instruction; v=0 gives a NOP.
    task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd, input logic rw, input logic ld);
        bus.id_valid    = v;
        bus.id_rs1      = rs1;
        bus.id_rs2      = rs2;
        bus.id_rd       = rd;
        bus.id_regwrite = rw;
        bus.id_memread  = ld;
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_sels(input string tag, input logic [1:0] a, input logic [1:0] b);
        check({tag, "_a"}, {30'd0, bus.fwd_a_sel}, {30'd0, a});
        check({tag, "_b"}, {30'd0, bus.fwd_b_sel}, {30'd0, b});
    endtask

    initial begin
        // Reset with random inputs: every output must read 0.
        set_id(1'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 1'($urandom), 1'($urandom));
        bus.mem_ready = 1'b0;
        #3;
        check("rst_stall", {31'd0, bus.stall}, 32'd0);
        check("rst_bubble", {31'd0, bus.ex_bubble}, 32'd0);
        check("rst_timeout", {31'd0, bus.mem_timeout}, 32'd0);
        check_sels("rst_sel", 2'b00, 2'b00);
        tick();
        check("rst_edge_stall", {31'd0, bus.stall}, 32'd0);
        rst = 1'b0;
        bus.mem_ready = 1'b1;
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_sels("idle_sel", 2'b00, 2'b00);
        end

        // EX forward: ADD x5 then SUB x8 <- x5, x6.
        set_id(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0);
        #1 check("add_stall", {31'd0, bus.stall}, 32'd0);
        tick();
        set_id(1'b1, 5'd5, 5'd6, 5'd8, 1'b1, 1'b0);
        tick();
        check_sels("ex_fwd", 2'b10, 2'b00);

        // WB forward: x7 producer, NOP, consumer reads rs2=x7.
        set_id(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0);
        tick();
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        tick();
        set_id(1'b1, 5'd1, 5'd7, 5'd9, 1'b0, 1'b0);
        tick();
        check_sels("wb_fwd", 2'b00, 2'b01);

        // Priority: two x7 producers back to back, newest (MEM result) wins.
        set_id(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5'd7, 5'd9, 5'd11, 1'b0, 1'b0);
        tick();
        check_sels("prio", 2'b10, 2'b00);

        // x0 producer never forwards.
        set_id(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5'd0, 5'd0, 5'd11, 1'b0, 1'b0);
        tick();
        check_sels("x0_prod", 2'b00, 2'b00);

        // A load to x0 is not a load-use hazard.
        set_id(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 5'd0, 5'd4, 5'd0, 1'b0, 1'b0);
        #1 check("lw_x0_stall", {31'd0, bus.stall}, 32'd0);
        tick();

        // Load-use: LW x3, then ADD x10 <- x3, x4: one bubble, then WB forward.
        set_id(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 5'd3, 5'd4, 5'd10, 1'b1, 1'b0);
        #1;
        check("lu_stall", {31'd0, bus.stall}, 32'd1);
        check("lu_bubble", {31'd0, bus.ex_bubble}, 32'd1);
        tick();
        check_sels("lu_bubble_sel", 2'b00, 2'b00);
        check("lu_stall2", {31'd0, bus.stall}, 32'd0);
        check("lu_bubble2", {31'd0, bus.ex_bubble}, 32'd0);
        tick();
        check_sels("lu_add_sel", 2'b01, 2'b00);

        // Mem wait: ADD x12 <- x10 enters EX, then memory stalls for 4 cycles.
        set_id(1'b1, 5'd10, 5'd0, 5'd12, 1'b1, 1'b0);
        tick();
        check_sels("pre_wait", 2'b10, 2'b00);
        set_id(1'b1, 5'd12, 5'd10, 5'd13, 1'b1, 1'b0);
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1 check("wait_stall", {31'd0, bus.stall}, 32'd1);
            check("wait_bubble", {31'd0, bus.ex_bubble}, 32'd0);
            tick();
            check_sels("wait_hold", 2'b10, 2'b00);
        end
        bus.mem_ready = 1'b1;
        #1 check("resume_stall", {31'd0, bus.stall}, 32'd0);
        tick();
        check_sels("resume_sel", 2'b10, 2'b01);
        check("wait4_timeout", {31'd0, bus.mem_timeout}, 32'd0);

        // Timeout: WAIT_LIMIT-1 waiting edges is still fine, the next one sets it.
        bus.mem_ready = 1'b0;
        for (int i = 0; i < WAIT_LIMIT - 1; i++) tick();
        check("timeout_early", {31'd0, bus.mem_timeout}, 32'd0);
        tick();
        check("timeout_set", {31'd0, bus.mem_timeout}, 32'd1);
        tick();
        check("timeout_sat", {31'd0, bus.mem_timeout}, 32'd1);
        bus.mem_ready = 1'b1;
        tick();
        check("timeout_sticky", {31'd0, bus.mem_timeout}, 32'd1);

        // Reset asserted mid-wait clears everything without a clock edge.
        bus.mem_ready = 1'b0;
        tick();
        tick();
        #2 rst = 1'b1;
        #1;
        check("arst_timeout", {31'd0, bus.mem_timeout}, 32'd0);
        check("arst_stall", {31'd0, bus.stall}, 32'd0);
        check_sels("arst_sel", 2'b00, 2'b00);
        tick();
        rst = 1'b0;
        bus.mem_ready = 1'b1;

        // Tracked instructions were discarded: reading x12/x13 forwards nothing.
        set_id(1'b1, 5'd12, 5'd13, 5'd14, 1'b1, 1'b0);
        tick();
        check_sels("post_rst_sel", 2'b00, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
